// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_arb_pkg;

  localparam int MAX_REQUESTERS = 8;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // Modulo add for index rings whose size need not be a power of two.
  function automatic int wrapAdd(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bus of uart_tx_arbiter; req_last_i exists only
// when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQUESTERS = 4
);
  import uart_tx_arb_pkg::*;

  logic [NUM_REQUESTERS-1:0]        req_valid_i;
  logic [BYTE_W*NUM_REQUESTERS-1:0] req_data_i;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQUESTERS-1:0]        req_last_i;
`endif
  logic [NUM_REQUESTERS-1:0]        req_ready_o;
  logic [NUM_REQUESTERS-1:0]        grant_o;
  logic                             tx_write_o;
  logic [BYTE_W-1:0]                tx_data_o;
  logic                             tx_busy_i;
  logic                             busy_o;

  modport slave (
`ifdef UART_TX_ARB_LOCK_EN
    input  req_last_i,
`endif
    input  req_valid_i, req_data_i, tx_busy_i,
    output req_ready_o, grant_o, tx_write_o, tx_data_o, busy_o
  );

  modport master (
`ifdef UART_TX_ARB_LOCK_EN
    output req_last_i,
`endif
    output req_valid_i, req_data_i, tx_busy_i,
    input  req_ready_o, grant_o, tx_write_o, tx_data_o, busy_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after the pointer.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot
);

  logic [N-1:0] w_rot;

  // Bit k of w_rot is requester (ptr + k) mod N; the doubled copy handles the wrap.
  assign w_rot = N'({i_valid, i_valid} >> i_ptr);

  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found         = 1'b1;
        o_idx           = IDX_W'(wrapAdd(int'(i_ptr), k, N));
        o_onehot        = '0;
        o_onehot[o_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter between NUM_REQUESTERS sources.
// Optional ownership lock across multi-byte messages: define UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input logic              clock_i,
  input logic              reset_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_WIDTH = $clog2(NUM_REQUESTERS);

  arb_state_t                r_state;
  arb_state_t                w_next;
  logic [IDX_WIDTH-1:0]      r_ptr;
  logic [NUM_REQUESTERS-1:0] r_ready;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic                      r_write;
  logic [BYTE_W-1:0]         r_data;

  logic [NUM_REQUESTERS-1:0] w_eligible;
  logic                      w_found;
  logic [IDX_WIDTH-1:0]      w_idx;
  logic [NUM_REQUESTERS-1:0] w_onehot;
  logic [IDX_WIDTH-1:0]      w_ptrNext;
  logic [BYTE_W-1:0]         w_selByte;
  logic                      w_start;
  logic                      w_advance;

  uart_rr_pick #(.N(NUM_REQUESTERS), .IDX_W(IDX_WIDTH)) u_pick (
    .i_valid  (w_eligible),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

`ifdef UART_TX_ARB_LOCK_EN
  logic                 r_locked;
  logic [IDX_WIDTH-1:0] r_owner;
  logic                 w_isLast;

  // While locked only the owner may win, and the pointer stays put until its last byte.
  assign w_eligible = r_locked ? (bus.req_valid_i & (NUM_REQUESTERS'(1) << r_owner))
                               : bus.req_valid_i;
  assign w_isLast   = |(bus.req_last_i & w_onehot);
  assign w_advance  = w_start & w_isLast;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
    end else if (w_start) begin
      r_locked <= ~w_isLast;
      r_owner  <= w_idx;
    end
  end
`else
  assign w_eligible = bus.req_valid_i;
  assign w_advance  = w_start;
`endif

  assign w_ptrNext = (int'(w_idx) == NUM_REQUESTERS - 1) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_selByte = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (w_onehot[k]) w_selByte = bus.req_data_i[k*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // A busy transmitter in IDLE also covers its own post-reset hold period.
  always_comb begin
    w_start = 1'b0;
    w_next  = r_state;
    case (r_state)
      IDLE: begin
        w_start = w_found & ~bus.tx_busy_i;
        if (w_start) w_next = ISSUE;
      end
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy_i)  w_next = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy_i) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_ready <= '0;
      r_grant <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
    end else begin
      r_write <= 1'b0;
      r_ready <= '0;
      if (w_start) begin
        r_write <= 1'b1;
        r_ready <= w_onehot;
        r_grant <= w_onehot;
        r_data  <= w_selByte;
      end
      if (w_advance) r_ptr <= w_ptrNext;
      if (r_state == WAIT_DONE && !bus.tx_busy_i) r_grant <= '0;
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.grant_o     = r_grant;
  assign bus.tx_write_o  = r_write;
  assign bus.tx_data_o   = r_data;
  assign bus.busy_o      = reset_i | (r_state != IDLE);

endmodule
